// File: rtl/cpu_defs.sv
// Shared definitions for the pipeline hazard unit: forwarding select codes,
// divider stall FSM state encoding and a small forwarding-select helper.
package cpu_defs;

    // Forwarding mux select codes (operand source for E-stage / HI-LO reads)
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Divider stall FSM states
    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } divState_t;

    // M beats W: the younger result in M is the most recent write
    function automatic logic [1:0] fwdSel(input logic hitM, input logic hitW);
        if (hitM)      return FWD_MEM;
        else if (hitW) return FWD_WB;
        else           return FWD_REG;
    endfunction

endpackage

// File: rtl/div_stall_fsm.sv
// Multi-cycle divider occupancy tracker. Counts unstalled cycles of a div/divu
// sitting in E and flags the final cycle so the pipe can release.
module div_stall_fsm
    import cpu_defs::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic divE,
    input  logic excM,
    input  logic memStall,
    output logic div_busy,
    output logic div_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

    divState_t        state;
    divState_t        stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;

    // State register: async reset drops any divide in flight immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next state: exception aborts, memory stall freezes, otherwise count
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        stateNext = state;
        cntNext   = cnt;
        if (excM) begin
            stateNext = DIV_IDLE;
            cntNext   = '0;
        end else if (!memStall) begin
            unique case (state)
                DIV_IDLE: begin
                    if (divE) begin
                        stateNext = DIV_RUN;
                        cntNext   = CNT_W'(1);
                    end
                end
                DIV_RUN: begin
                    if (cnt == LAST_CNT) begin
                        stateNext = DIV_IDLE;
                        cntNext   = '0;
                    end else begin
                        cntNext = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    stateNext = DIV_IDLE;
                    cntNext   = '0;
                end
            endcase
        end
    end

    // Outputs: busy from the first cycle the div sits in E; done on the last unstalled cycle
    always_comb begin
        div_busy = ((state == DIV_IDLE) && divE) || (state == DIV_RUN);
        div_done = (state == DIV_RUN) && (cnt == LAST_CNT) && !memStall;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: combinational forwarding
// selects plus fixed-priority stall/flush generation (exception, memory,
// divider, load-use/branch).
module hazard_ctrl
    import cpu_defs::*;
#(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    // D stage
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              jrD,
    output logic              forwardaD,
    output logic              forwardbD,
    // E stage
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic [1:0]        hilo_readE,
    input  logic              divE,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic [1:0]        forwardhiE,
    output logic [1:0]        forwardloE,
    // M stage
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              hi_writeM,
    input  logic              lo_writeM,
    input  logic              excM,
    // W stage
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    input  logic              hi_writeW,
    input  logic              lo_writeW,
    // Memories
    input  logic              i_stall,
    input  logic              d_stall,
    // Pipe control
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              stallW,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              div_busy,
    output logic              div_done
);

    logic memStall;
    logic lwStall;
    logic brStall;
    logic hitMrsE, hitWrsE, hitMrtE, hitWrtE;
    logic exDepD, memDepD;

    assign memStall = i_stall | d_stall;

    // GPR forwarding into E; register 0 never matches
    assign hitMrsE = (rsE != '0) && (rsE == writeregM) && regwriteM;
    assign hitWrsE = (rsE != '0) && (rsE == writeregW) && regwriteW;
    assign hitMrtE = (rtE != '0) && (rtE == writeregM) && regwriteM;
    assign hitWrtE = (rtE != '0) && (rtE == writeregW) && regwriteW;

    assign forwardaE  = fwdSel(hitMrsE, hitWrsE);
    assign forwardbE  = fwdSel(hitMrtE, hitWrtE);
    assign forwardhiE = fwdSel(hilo_readE[1] & hi_writeM, hilo_readE[1] & hi_writeW);
    assign forwardloE = fwdSel(hilo_readE[0] & lo_writeM, hilo_readE[0] & lo_writeW);

    // Branch comparator operands in D take the M ALU result
    assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

    // Load-use: the load in E has no data until after M
    assign lwStall = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));

    // Branch/jr resolve in D, so they wait on an ALU result in E or a load in M
    assign exDepD  = regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
    assign memDepD = memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));
    assign brStall = (branchD || jrD) && (exDepD || memDepD);

    div_stall_fsm #(
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) uDivFsm (
        .clk     (clk),
        .rst     (rst),
        .divE    (divE),
        .excM    (excM),
        .memStall(memStall),
        .div_busy(div_busy),
        .div_done(div_done)
    );

    // Fixed-priority stall/flush arbitration: exception > memory > divider > load/branch
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        stallW = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (excM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (memStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            stallW = 1'b1;
        end else if (div_busy && !div_done) begin
            // div holds E; feed bubbles into M behind it
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lwStall || brStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int DIV_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       branchD, jrD, regwriteE, memtoregE, divE;
    logic [1:0] hilo_readE;
    logic       regwriteM, memtoregM, hi_writeM, lo_writeM, excM;
    logic       regwriteW, hi_writeW, lo_writeW, i_stall, d_stall;
    logic       forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE, forwardhiE, forwardloE;
    logic       stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM;
    logic       div_busy, div_done;

    int checks = 0;
    int errors = 0;

    // Model of the divider: is a divide in progress, and how many unstalled cycles remain
    bit mActive;
    int mLeft;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .DIV_CYCLES(DIV_CYCLES), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .hilo_readE(hilo_readE), .divE(divE),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .forwardhiE(forwardhiE), .forwardloE(forwardloE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .hi_writeM(hi_writeM), .lo_writeM(lo_writeM), .excM(excM),
        .writeregW(writeregW), .regwriteW(regwriteW),
        .hi_writeW(hi_writeW), .lo_writeW(lo_writeW),
        .i_stall(i_stall), .d_stall(d_stall),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .div_busy(div_busy), .div_done(div_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int fwdGpr(input logic [4:0] src);
        if (src != 0 && src == writeregM && regwriteM) return 2;
        if (src != 0 && src == writeregW && regwriteW) return 1;
        return 0;
    endfunction

    function automatic int fwdHiLo(input logic rd, input logic wrM, input logic wrW);
        if (rd && wrM) return 2;
        if (rd && wrW) return 1;
        return 0;
    endfunction

    function automatic bit dependsOn(input logic [4:0] w);
        return w != 0 && (w == rsD || w == rtD);
    endfunction

    task automatic clearInputs();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {branchD, jrD, regwriteE, memtoregE, divE, hilo_readE} = '0;
        {regwriteM, memtoregM, hi_writeM, lo_writeM, excM} = '0;
        {regwriteW, hi_writeW, lo_writeW, i_stall, d_stall} = '0;
    endtask

    // Let inputs settle, then compare every output with the model
    task automatic settle();
        bit ms, lw, br, busy, done;
        bit sF, sD, sE, sM, sW, fD, fE, fM;
        #1;
        ms   = i_stall || d_stall;
        lw   = memtoregE && rtE != 0 && (rtE == rsD || rtE == rtD);
        br   = (branchD || jrD) && ((regwriteE && dependsOn(writeregE)) || (memtoregM && dependsOn(writeregM)));
        busy = mActive || divE;
        done = mActive && mLeft == 1 && !ms;
        {sF, sD, sE, sM, sW, fD, fE, fM} = '0;
        if (excM)                  {fD, fE, fM} = 3'b111;
        else if (ms)               {sF, sD, sE, sM, sW} = 5'b11111;
        else if (busy && !done)    {sF, sD, sE, fM} = 4'b1111;
        else if (lw || br)         {sF, sD, fE} = 3'b111;
        check("forwardaE", 32'(forwardaE), fwdGpr(rsE));
        check("forwardbE", 32'(forwardbE), fwdGpr(rtE));
        check("forwardhiE", 32'(forwardhiE), fwdHiLo(hilo_readE[1], hi_writeM, hi_writeW));
        check("forwardloE", 32'(forwardloE), fwdHiLo(hilo_readE[0], lo_writeM, lo_writeW));
        check("forwardaD", 32'(forwardaD), 32'(rsD != 0 && rsD == writeregM && regwriteM));
        check("forwardbD", 32'(forwardbD), 32'(rtD != 0 && rtD == writeregM && regwriteM));
        check("stalls", 32'({stallF, stallD, stallE, stallM, stallW}), 32'({sF, sD, sE, sM, sW}));
        check("flushes", 32'({flushD, flushE, flushM}), 32'({fD, fE, fM}));
        check("div_busy", 32'(div_busy), 32'(busy));
        check("div_done", 32'(div_done), 32'(done));
    endtask

    // Clock edge: advance the divider model with the inputs present at the edge
    task automatic advance();
        @(posedge clk);
        if (excM)                          mActive = 0;
        else if (i_stall || d_stall)       ;
        else if (!mActive && divE)         begin mActive = 1; mLeft = DIV_CYCLES - 1; end
        else if (mActive && mLeft == 1)    mActive = 0;
        else if (mActive)                  mLeft--;
        @(negedge clk);
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        mActive = 0;
        mLeft = 0;
        @(negedge clk);
        settle();
        check("reset stallF", 32'(stallF), 0);
        @(negedge clk);
        rst = 1'b0;

        // GPR forwarding: M beats W, register 0 never forwards
        rsE = 8; writeregM = 8; regwriteM = 1; writeregW = 8; regwriteW = 1;
        settle();
        check("fwd M over W", 32'(forwardaE), 2);
        rsE = 0;
        settle();
        check("fwd r0", 32'(forwardaE), 0);
        advance();

        // Load-use stall, and none when the load targets r0
        clearInputs();
        memtoregE = 1; rtE = 9; rsD = 9;
        settle();
        check("lwstall", 32'({stallF, stallD, flushE}), 3'b111);
        rtE = 0;
        settle();
        check("lwstall r0", 32'({stallF, stallD, flushE}), 0);
        advance();

        // Branch waits on E ALU result, then on load in M, then forwards from M
        clearInputs();
        branchD = 1; rsD = 4; regwriteE = 1; writeregE = 4;
        settle();
        check("brstall E", 32'(stallD), 1);
        advance();
        regwriteE = 0; writeregE = 0; memtoregM = 1; writeregM = 4; regwriteM = 1;
        settle();
        check("brstall M", 32'(stallD), 1);
        memtoregM = 0;
        settle();
        check("br fwd M", 32'({stallD, forwardaD}), 2'b01);
        advance();

        // Divide: stall cycles 0..DIV_CYCLES-2, done on the last
        clearInputs();
        divE = 1;
        for (int t = 0; t < DIV_CYCLES; t++) begin
            settle();
            check("div stallE", 32'({stallE, flushM}), (t < DIV_CYCLES - 1) ? 2'b11 : 2'b00);
            check("div done", 32'(div_done), 32'(t == DIV_CYCLES - 1));
            advance();
        end
        divE = 0;
        settle();
        advance();

        // Memory stall during divide holds the counter
        divE = 1;
        settle(); advance();
        settle(); advance();
        d_stall = 1;
        for (int t = 0; t < 3; t++) begin
            settle();
            check("dstall stallW", 32'({stallW, div_done}), 2'b10);
            advance();
        end
        d_stall = 0;
        settle();
        check("release not done", 32'(div_done), 0);
        advance();
        settle();
        check("done after release", 32'(div_done), 1);
        advance();
        divE = 0;

        // Exception aborts divide even under a memory stall
        divE = 1;
        settle(); advance();
        settle(); advance();
        excM = 1; d_stall = 1;
        settle();
        check("exc flush", 32'({flushD, flushE, flushM, stallW}), 4'b1110);
        advance();
        excM = 0; d_stall = 0; divE = 0;
        settle();
        check("exc abort busy", 32'(div_busy), 0);
        advance();

        // HI/LO forwarding
        clearInputs();
        hilo_readE = 2'b10; hi_writeM = 1; lo_writeW = 1;
        settle();
        check("fwd hi", 32'({forwardhiE, forwardloE}), 4'b1000);
        advance();

        // Asynchronous reset mid-divide
        clearInputs();
        divE = 1;
        settle(); advance();
        settle(); advance();
        divE = 0;
        rst = 1'b1;
        mActive = 0;
        #1;
        check("async rst busy", 32'(div_busy), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic with small register indices to provoke matches
        for (int n = 0; n < 600; n++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            branchD = ($urandom_range(0, 3) == 0); jrD = ($urandom_range(0, 5) == 0);
            regwriteE = 1'($urandom); memtoregE = ($urandom_range(0, 3) == 0);
            hilo_readE = 2'($urandom);
            regwriteM = 1'($urandom); memtoregM = ($urandom_range(0, 3) == 0);
            hi_writeM = 1'($urandom); lo_writeM = 1'($urandom);
            regwriteW = 1'($urandom); hi_writeW = 1'($urandom); lo_writeW = 1'($urandom);
            excM = ($urandom_range(0, 19) == 0);
            i_stall = ($urandom_range(0, 7) == 0); d_stall = ($urandom_range(0, 7) == 0);
            divE = mActive ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0);
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
